// File: rtl/seq_run_detector_if.sv
// Sample/control inputs and detection outputs of the run detector.
// The stimulus side uses master; the detector uses slave.
interface seq_run_detector_if #(
    parameter int unsigned CNT_W = 8
) ();
    logic             en;
    logic             w;
    logic             mode;
    logic             clr_cnt;
    logic             z;
    logic             z_val;
    logic [3:0]       run_cnt;
    logic [CNT_W-1:0] det_cnt;

    modport master (
        output en, w, mode, clr_cnt,
        input  z, z_val, run_cnt, det_cnt
    );

    modport slave (
        input  en, w, mode, clr_cnt,
        output z, z_val, run_cnt, det_cnt
    );
endinterface

// File: rtl/seq_run_detector.sv
// Detects runs of RUN_LEN identical serial samples, in sticky or repeating mode,
// and keeps a saturating count of detections.
module seq_run_detector #(
    parameter int unsigned RUN_LEN = 4,
    parameter int unsigned CNT_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    seq_run_detector_if.slave bus
);
    localparam logic [3:0]       RLEN    = 4'(RUN_LEN);
    localparam logic [3:0]       RLEN_M1 = 4'(RUN_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, RUN0, RUN1} state_t;

    state_t           state, state_nxt;
    logic [3:0]       r, r_nxt;
    logic [CNT_W-1:0] det, det_nxt;
    logic             z, z_nxt;
    logic             z_val, z_val_nxt;
    logic             hit;

    // z/z_val are registered from next state, so they equal a decode of the state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            r     <= 4'd0;
            det   <= '0;
            z     <= 1'b0;
            z_val <= 1'b0;
        end else begin
            state <= state_nxt;
            r     <= r_nxt;
            det   <= det_nxt;
            z     <= z_nxt;
            z_val <= z_val_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        r_nxt     = r;
        det_nxt   = det;
        hit       = 1'b0;

        if (bus.en) begin
            unique case (state)
                IDLE: begin
                    state_nxt = bus.w ? RUN1 : RUN0;
                    r_nxt     = 4'd1;
                end
                RUN0, RUN1: begin
                    if (bus.w != (state == RUN1)) begin
                        state_nxt = bus.w ? RUN1 : RUN0;
                        r_nxt     = 4'd1;
                    end else if (r == RLEN) begin
                        r_nxt = bus.mode ? 4'd1 : RLEN;
                    end else begin
                        r_nxt = r + 4'd1;
                        hit   = (r == RLEN_M1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    r_nxt     = 4'd0;
                end
            endcase
        end

        // clear beats a coincident detection
        if (bus.clr_cnt) begin
            det_nxt = '0;
        end else if (hit && (det != CNT_MAX)) begin
            det_nxt = det + CNT_W'(1);
        end

        z_nxt     = (state_nxt != IDLE) && (r_nxt == RLEN);
        z_val_nxt = (state_nxt == RUN1);
    end

    assign bus.z       = z;
    assign bus.z_val   = z_val;
    assign bus.run_cnt = r;
    assign bus.det_cnt = det;
endmodule

// File: tb/tb_seq_run_detector.sv
// Scoreboard bench for seq_run_detector: an 8-bit and a 2-bit counter instance
// run the same stimulus against a behavioural reference.
module tb_seq_run_detector;
    localparam int RUN_LEN = 4;

    typedef struct packed {
        logic       z;
        logic       z_val;
        logic [3:0] run_cnt;
        logic [7:0] det_a;
        logic [1:0] det_b;
    } obs_t;

    logic clk;
    logic reset;
    logic en, w, mode, clr;

    seq_run_detector_if #(.CNT_W(8)) ifa ();
    seq_run_detector_if #(.CNT_W(2)) ifb ();

    assign ifa.en = en;  assign ifa.w = w;  assign ifa.mode = mode;  assign ifa.clr_cnt = clr;
    assign ifb.en = en;  assign ifb.w = w;  assign ifb.mode = mode;  assign ifb.clr_cnt = clr;

    seq_run_detector #(.RUN_LEN(RUN_LEN), .CNT_W(8)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
    seq_run_detector #(.RUN_LEN(RUN_LEN), .CNT_W(2)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    obs_t exp_q[$];

    // reference: ms 0=idle 1=run of zeros 2=run of ones
    int ms, mr, mda, mdb;

    function automatic void model_reset();
        ms = 0; mr = 0; mda = 0; mdb = 0;
    endfunction

    function automatic void model_step(input logic e, input logic wv, input logic m, input logic c);
        bit det = 0;
        if (e) begin
            if (ms == 0 || ms != (wv ? 2 : 1)) begin
                ms = wv ? 2 : 1;
                mr = 1;
            end else if (mr == RUN_LEN) begin
                mr = m ? 1 : RUN_LEN;
            end else begin
                mr = mr + 1;
                det = (mr == RUN_LEN);
            end
        end
        if (det) begin
            if (mda < 255) mda++;
            if (mdb < 3) mdb++;
        end
        if (c) begin
            mda = 0; mdb = 0;
        end
    endfunction

    function automatic obs_t model_out();
        obs_t o;
        o.z       = (ms != 0) && (mr == RUN_LEN);
        o.z_val   = (ms == 2);
        o.run_cnt = 4'(mr);
        o.det_a   = 8'(mda);
        o.det_b   = 2'(mdb);
        return o;
    endfunction

    function automatic obs_t observed();
        return {ifa.z, ifa.z_val, ifa.run_cnt, ifa.det_cnt, ifb.det_cnt};
    endfunction

    // drive one sample, queue its expected result, and land #1 after the edge
    task automatic apply(input logic e, input logic wv, input logic m, input logic c);
        en = e; w = wv; mode = m; clr = c;
        model_step(e, wv, m, c);
        exp_q.push_back(model_out());
        @(posedge clk);
        #1;
    endtask

    task automatic restart();
        en = 1'b0; clr = 1'b0;
        reset = 1'b0;
        model_reset();
        exp_q.delete();
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t g;
        reset = 1'b0; en = 1'b0; w = 1'b0; mode = 1'b0; clr = 1'b0;
        model_reset();
        #3;
        g = observed();
        n_tests++;
        if (g !== obs_t'(0) || ifb.z !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got %h, expected 0000", g);
        end
        #4 reset = 1'b1;
        #5;
        g = observed();
        n_tests++;
        if (g !== obs_t'(0)) begin
            n_fail++;
            $display("FAIL reset_release_hold: got %h, expected 0000", g);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_sticky();
        int   tr[6] = '{1, 2, 3, 4, 4, 4};
        obs_t g, x;
        restart();
        for (int i = 0; i < 6; i++) begin
            apply(1'b1, 1'b1, 1'b0, 1'b0);
            g = observed(); x = exp_q.pop_front();
            n_tests++;
            if (g !== x || g.run_cnt !== 4'(tr[i]) || g.z !== (i >= 3)) begin
                n_fail++;
                $display("FAIL sticky[%0d]: got z=%b zv=%b r=%0d det=%0d, expected z=%b zv=%b r=%0d det=%0d",
                         i, g.z, g.z_val, g.run_cnt, g.det_a, x.z, x.z_val, tr[i], x.det_a);
            end
        end
        n_tests++;
        if (ifa.det_cnt !== 8'd1 || ifa.z_val !== 1'b1) begin
            n_fail++;
            $display("FAIL sticky_end: got det=%0d zv=%b, expected det=1 zv=1", ifa.det_cnt, ifa.z_val);
        end
    endtask

    task automatic test_repeat();
        int   tr[9] = '{1, 2, 3, 4, 1, 2, 3, 4, 1};
        obs_t g, x;
        restart();
        for (int i = 0; i < 9; i++) begin
            apply(1'b1, 1'b0, 1'b1, 1'b0);
            g = observed(); x = exp_q.pop_front();
            n_tests++;
            if (g !== x || g.run_cnt !== 4'(tr[i]) || g.z !== (i == 3 || i == 7) || g.z_val !== 1'b0) begin
                n_fail++;
                $display("FAIL repeat[%0d]: got z=%b zv=%b r=%0d det=%0d, expected z=%b zv=0 r=%0d det=%0d",
                         i, g.z, g.z_val, g.run_cnt, g.det_a, x.z, tr[i], x.det_a);
            end
        end
        n_tests++;
        if (ifa.det_cnt !== 8'd2) begin
            n_fail++;
            $display("FAIL repeat_det: got %0d, expected 2", ifa.det_cnt);
        end
    endtask

    task automatic test_polarity();
        logic sv[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        obs_t g, x;
        restart();
        for (int i = 0; i < 7; i++) begin
            apply(1'b1, sv[i], 1'b0, 1'b0);
            g = observed(); x = exp_q.pop_front();
            n_tests++;
            if (g !== x || g.z !== (i == 6)) begin
                n_fail++;
                $display("FAIL polarity[%0d]: got z=%b zv=%b r=%0d det=%0d, expected z=%b zv=%b r=%0d det=%0d",
                         i, g.z, g.z_val, g.run_cnt, g.det_a, x.z, x.z_val, x.run_cnt, x.det_a);
            end
        end
        n_tests++;
        if (ifa.z_val !== 1'b0 || ifa.det_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL polarity_end: got zv=%b det=%0d, expected zv=0 det=1", ifa.z_val, ifa.det_cnt);
        end
        // a flip right at the detected length drops z and counts nothing extra
        apply(1'b1, 1'b1, 1'b0, 1'b0);
        g = observed(); x = exp_q.pop_front();
        n_tests++;
        if (g !== x || g.run_cnt !== 4'd1 || g.z !== 1'b0 || g.det_a !== 8'd1) begin
            n_fail++;
            $display("FAIL polarity_flip: got z=%b r=%0d det=%0d, expected z=0 r=1 det=1",
                     g.z, g.run_cnt, g.det_a);
        end
    endtask

    task automatic test_enable();
        int   tr[8] = '{1, 1, 2, 2, 3, 3, 4, 4};
        obs_t g, x;
        restart();
        for (int i = 0; i < 8; i++) begin
            apply((i % 2) == 0, 1'b1, 1'b0, 1'b0);
            g = observed(); x = exp_q.pop_front();
            n_tests++;
            if (g !== x || g.run_cnt !== 4'(tr[i]) || g.z !== (i >= 6)) begin
                n_fail++;
                $display("FAIL enable[%0d]: got z=%b r=%0d det=%0d, expected z=%b r=%0d det=%0d",
                         i, g.z, g.run_cnt, g.det_a, x.z, tr[i], x.det_a);
            end
        end
    endtask

    task automatic test_saturate();
        obs_t g, x;
        restart();
        for (int i = 0; i < 24; i++) begin
            // edge 24 is a detection edge coinciding with clr
            apply(1'b1, 1'b1, 1'b1, i == 23);
            g = observed(); x = exp_q.pop_front();
            n_tests++;
            if (g !== x) begin
                n_fail++;
                $display("FAIL saturate[%0d]: got r=%0d da=%0d db=%0d, expected r=%0d da=%0d db=%0d",
                         i, g.run_cnt, g.det_a, g.det_b, x.run_cnt, x.det_a, x.det_b);
            end
            if (i == 19) begin
                n_tests++;
                if (g.det_b !== 2'd3 || g.det_a !== 8'd5) begin
                    n_fail++;
                    $display("FAIL saturate_max: got db=%0d da=%0d, expected db=3 da=5", g.det_b, g.det_a);
                end
            end
        end
        n_tests++;
        if (ifb.det_cnt !== 2'd0 || ifa.det_cnt !== 8'd0 || ifb.z !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_wins: got db=%0d da=%0d z=%b, expected db=0 da=0 z=1",
                     ifb.det_cnt, ifa.det_cnt, ifb.z);
        end
    endtask

    task automatic test_mode_switch();
        obs_t g, x;
        restart();
        for (int i = 0; i < 5; i++) begin
            apply(1'b1, 1'b1, 1'b0, 1'b0);
            void'(exp_q.pop_front());
        end
        apply(1'b1, 1'b1, 1'b1, 1'b0);
        g = observed(); x = exp_q.pop_front();
        n_tests++;
        if (g !== x || g.run_cnt !== 4'd1 || g.z !== 1'b0 || g.det_a !== 8'd1) begin
            n_fail++;
            $display("FAIL mode_switch: got z=%b r=%0d det=%0d, expected z=0 r=1 det=1",
                     g.z, g.run_cnt, g.det_a);
        end
    endtask

    task automatic test_reset_mid();
        obs_t g, x;
        restart();
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, 1'b1, 1'b0, 1'b0);
            void'(exp_q.pop_front());
        end
        n_tests++;
        if (ifa.z !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_setup: got z=%b, expected 1", ifa.z);
        end
        #2 reset = 1'b0;
        #1;
        g = observed();
        n_tests++;
        if (g !== obs_t'(0)) begin
            n_fail++;
            $display("FAIL reset_mid_async: got z=%b r=%0d da=%0d db=%0d, expected all 0",
                     g.z, g.run_cnt, g.det_a, g.det_b);
        end
        #1 reset = 1'b1;
        model_reset();
        #2;
        n_tests++;
        if (observed() !== obs_t'(0)) begin
            n_fail++;
            $display("FAIL reset_mid_hold: got %h, expected 0000", observed());
        end
        apply(1'b1, 1'b0, 1'b0, 1'b0);
        g = observed(); x = exp_q.pop_front();
        n_tests++;
        if (g !== x || g.run_cnt !== 4'd1 || g.z_val !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_restart: got r=%0d zv=%b, expected r=1 zv=0", g.run_cnt, g.z_val);
        end
    endtask

    task automatic test_back_to_back();
        obs_t g, x;
        logic wv = 1'b0;
        logic m  = 1'b0;
        restart();
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(4, 0) == 0) wv = ~wv;
            if ($urandom_range(7, 0) == 0) m = ~m;
            apply($urandom_range(3, 0) != 0, wv, m, $urandom_range(15, 0) == 0);
            g = observed(); x = exp_q.pop_front();
            n_tests++;
            if (g !== x) begin
                n_fail++;
                $display("FAIL random[%0d]: got z=%b zv=%b r=%0d da=%0d db=%0d, expected z=%b zv=%b r=%0d da=%0d db=%0d",
                         i, g.z, g.z_val, g.run_cnt, g.det_a, g.det_b,
                         x.z, x.z_val, x.run_cnt, x.det_a, x.det_b);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_sticky();
        test_repeat();
        test_polarity();
        test_enable();
        test_saturate();
        test_mode_switch();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/seq_run_detector.md
SEQ_RUN_DETECTOR -- requirements
Module: seq_run_detector

Interface
REQ-001 The block SHALL have parameter RUN_LEN, default 4, setting the number of consecutive identical samples that forms a run (legal range 2..15).
REQ-002 The block SHALL have parameter CNT_W, default 8, setting the width of the detection counter (legal range 1..16).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port en, input, 1 bit: sample enable; w is sampled only on edges where en=1.
REQ-006 The block SHALL have port w, input, 1 bit: serial data sample.
REQ-007 The block SHALL have port mode, input, 1 bit: 0 = sticky (z holds while the run continues), 1 = repeating (z pulses once per RUN_LEN matching samples).
REQ-008 The block SHALL have port clr_cnt, input, 1 bit: synchronous clear of det_cnt.
REQ-009 The block SHALL have port z, output, 1 bit: run detected.
REQ-010 The block SHALL have port z_val, output, 1 bit: value of the current run (0-run or 1-run).
REQ-011 The block SHALL have port run_cnt, output, 4 bits: current run length r (0 in IDLE).
REQ-012 The block SHALL have port det_cnt, output, CNT_W bits: saturating count of detections.

Function
REQ-013 The block SHALL implement an FSM with states IDLE, RUN0 and RUN1, plus a run counter r (4 bits).
REQ-014 On an edge with en=1 in IDLE, the FSM SHALL move to RUN<w> with r=1.
REQ-015 On an edge with en=1 in RUN<b> with w!=b, the FSM SHALL move to RUN<w> with r=1.
REQ-016 On an edge with en=1 in RUN<b> with w==b and mode=0, r SHALL become min(r+1, RUN_LEN).
REQ-017 On an edge with en=1 in RUN<b> with w==b and mode=1, r SHALL become 1 if r==RUN_LEN, else r+1.
REQ-018 On edges with en=0, the FSM state, r and det_cnt SHALL all hold; clr_cnt still applies.
REQ-019 z SHALL be a Moore output, z = (state!=IDLE) AND (r==RUN_LEN), decoded from registers only, with no combinational path from w, en or mode.
REQ-020 z SHALL therefore rise in the cycle after the edge that samples the RUN_LEN-th matching bit (latency 1 clock).
REQ-021 z_val SHALL be 1 in RUN1 and 0 in RUN0 and IDLE.
REQ-022 run_cnt SHALL equal r.
REQ-023 det_cnt SHALL increment by 1 on every edge where r transitions to RUN_LEN from a value other than RUN_LEN.
REQ-024 det_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-025 When clr_cnt=1 on an edge, det_cnt SHALL become 0; clr_cnt wins over a simultaneous increment.
REQ-026 A mode change SHALL take effect at the next en=1 edge; mode 0->1 while r==RUN_LEN with a matching sample gives r=1 and z falls.
REQ-027 A polarity change at r==RUN_LEN SHALL drop z at the next edge and start the opposite run at r=1, with no extra detection counted.

Reset
REQ-028 Assertion of reset=0 SHALL asynchronously force state=IDLE, r=0, det_cnt=0, z=0, z_val=0, independent of clk.
REQ-029 Reset asserted mid-run SHALL discard the run; after release the first en=1 edge enters RUN<w> with r=1.
REQ-030 Reset release SHALL take effect only at clock edges; no state change may occur between release and the next rising edge.

Verification
REQ-031 The bench SHALL cover: RUN_LEN=4, mode=0, en=1, w=1,1,1,1,1,1 -> run_cnt 1,2,3,4,4,4; z high from the cycle after the 4th edge; z_val=1; det_cnt=1.
REQ-032 The bench SHALL cover: mode=1, w=0 for 9 edges -> z pulses one cycle after edges 4 and 8; run_cnt 1,2,3,4,1,2,3,4,1; det_cnt=2; z_val=0.
REQ-033 The bench SHALL cover: w=1,1,1,0,0,0,0 -> no z during the 1s; z rises after the 7th edge with z_val=0; det_cnt=1.
REQ-034 The bench SHALL cover: en toggling 1,0,1,0,... with w=1 constant -> r advances only on en=1 edges; z after the 4th enabled edge.
REQ-035 The bench SHALL cover: CNT_W=2, mode=1, 20 matching samples -> det_cnt saturates at 3; clr_cnt=1 coincident with a detection edge -> det_cnt=0.
REQ-036 The bench SHALL cover: reset=0 pulse between clock edges while z=1 -> z, run_cnt and det_cnt go to 0 immediately; after release, the first en=1 edge gives run_cnt=1.
